// File: rtl/hazard_forward_unit_pkg.sv
// Shared encodings for the hazard/forwarding unit and the execute-stage forward muxes.
package hazard_forward_unit_pkg;

  localparam int unsigned REG_W = 5;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    FWD_IDEX  = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MEMWAIT = 2'd1,
    ST_ERROR   = 2'd2
  } state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/hazard_forward_unit_if.sv
// Pipeline-side signals of the hazard/forwarding unit; the core drives the master side.
interface hazard_forward_unit_if;
  import hazard_forward_unit_pkg::*;

  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_uses_rt;
  logic [REG_W-1:0] idex_writeReg;
  logic             idex_regwrite;
  logic             idex_memread;
  logic             mem_ready;

  logic [1:0]       fwdA;
  logic [1:0]       fwdB;
  logic             pc_write;
  logic             ifid_write;
  logic             idex_bubble;
  logic             pipe_freeze;
  logic             mem_err;

  // Shadow copies of the later pipeline stages, exposed for observability
  logic [REG_W-1:0] exmem_wr;
  logic             exmem_rw;
  logic             exmem_mr;
  logic [REG_W-1:0] memwb_wr;
  logic             memwb_rw;

  modport master (
    output id_rs, id_rt, id_uses_rt, idex_writeReg, idex_regwrite, idex_memread, mem_ready,
    input  fwdA, fwdB, pc_write, ifid_write, idex_bubble, pipe_freeze, mem_err,
    input  exmem_wr, exmem_rw, exmem_mr, memwb_wr, memwb_rw
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, idex_writeReg, idex_regwrite, idex_memread, mem_ready,
    output fwdA, fwdB, pc_write, ifid_write, idex_bubble, pipe_freeze, mem_err,
    output exmem_wr, exmem_rw, exmem_mr, memwb_wr, memwb_rw
  );

endinterface

// File: rtl/hazard_forward_unit_fwd_select.sv
// Per-operand forward select: the younger producer (now entering EX/MEM) beats the older one.
module hazard_forward_unit_fwd_select
  import hazard_forward_unit_pkg::*;
(
  input  logic [REG_W-1:0] src_i,
  input  logic [REG_W-1:0] idex_wr_i,
  input  logic             idex_rw_i,
  input  logic [REG_W-1:0] exmem_wr_i,
  input  logic             exmem_rw_i,
  output fwd_sel_e         sel_o
);

  always_comb begin
    sel_o = FWD_IDEX;
    if (idex_rw_i && (idex_wr_i != '0) && (idex_wr_i == src_i)) begin
      sel_o = FWD_EXMEM;
    end else if (exmem_rw_i && (exmem_wr_i != '0) && (exmem_wr_i == src_i)) begin
      sel_o = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// Load-use stall, memory-wait freeze with timeout, and registered forward selects
// computed one stage ahead of execute.
module hazard_forward_unit
  import hazard_forward_unit_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input logic                  clk,
  input logic                  reset_n,
  hazard_forward_unit_if.slave bus
);

  // state      | meaning
  // ST_RUN     | normal flow, load-use bubbles allowed
  // ST_MEMWAIT | EX/MEM access stalled, counting wait cycles
  // ST_ERROR   | memory timed out, pipeline frozen until reset

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MEM_TIMEOUT);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  logic [REG_W-1:0] exmem_wr_q, memwb_wr_q;
  logic             exmem_rw_q, exmem_mr_q, memwb_rw_q;
  fwd_sel_e         fwd_a_q, fwd_b_q;
  fwd_sel_e         sel_a, sel_b;

  logic load_use;
  logic freeze;
  logic bubble;

  assign load_use = bus.idex_memread && (bus.idex_writeReg != '0) &&
                    ((bus.idex_writeReg == bus.id_rs) ||
                     (bus.id_uses_rt && (bus.idex_writeReg == bus.id_rt)));

  assign freeze = (exmem_mr_q && !bus.mem_ready) || (state_q == ST_ERROR);

  // A stall deferred by a freeze fires in the first unfrozen cycle, which may
  // still be the MEMWAIT exit cycle; reset_n masks it while reset is held.
  assign bubble = reset_n && !freeze && load_use;

  hazard_forward_unit_fwd_select u_fwd_select_a (
    .src_i      (bus.id_rs),
    .idex_wr_i  (bus.idex_writeReg),
    .idex_rw_i  (bus.idex_regwrite),
    .exmem_wr_i (exmem_wr_q),
    .exmem_rw_i (exmem_rw_q),
    .sel_o      (sel_a)
  );

  hazard_forward_unit_fwd_select u_fwd_select_b (
    .src_i      (bus.id_rt),
    .idex_wr_i  (bus.idex_writeReg),
    .idex_rw_i  (bus.idex_regwrite),
    .exmem_wr_i (exmem_wr_q),
    .exmem_rw_i (exmem_rw_q),
    .sel_o      (sel_b)
  );

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      ST_RUN: begin
        if (freeze) begin
          state_d    = ST_MEMWAIT;
          wait_cnt_d = '0;
        end
      end
      ST_MEMWAIT: begin
        if (bus.mem_ready) begin
          state_d = ST_RUN;
        end else begin
          wait_cnt_d = sat_inc(wait_cnt_q);
          if (wait_cnt_d == TIMEOUT_CNT) begin
            state_d = ST_ERROR;
          end
        end
      end
      ST_ERROR: begin
        state_d = ST_ERROR;
      end
      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      exmem_wr_q <= '0;
      exmem_rw_q <= 1'b0;
      exmem_mr_q <= 1'b0;
      memwb_wr_q <= '0;
      memwb_rw_q <= 1'b0;
      fwd_a_q    <= FWD_IDEX;
      fwd_b_q    <= FWD_IDEX;
    end else if (!freeze) begin
      exmem_wr_q <= bus.idex_writeReg;
      exmem_rw_q <= bus.idex_regwrite;
      exmem_mr_q <= bus.idex_memread;
      memwb_wr_q <= exmem_wr_q;
      memwb_rw_q <= exmem_rw_q;
      // A NOP enters ID/EX on a bubble, so it must not forward anything.
      if (bubble) begin
        fwd_a_q <= FWD_IDEX;
        fwd_b_q <= FWD_IDEX;
      end else begin
        fwd_a_q <= sel_a;
        fwd_b_q <= sel_b;
      end
    end
  end

  assign bus.fwdA        = fwd_a_q;
  assign bus.fwdB        = fwd_b_q;
  assign bus.pc_write    = !freeze && !bubble;
  assign bus.ifid_write  = !freeze && !bubble;
  assign bus.idex_bubble = bubble;
  assign bus.pipe_freeze = freeze;
  assign bus.mem_err     = (state_q == ST_ERROR);

  assign bus.exmem_wr = exmem_wr_q;
  assign bus.exmem_rw = exmem_rw_q;
  assign bus.exmem_mr = exmem_mr_q;
  assign bus.memwb_wr = memwb_wr_q;
  assign bus.memwb_rw = memwb_rw_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Bench for hazard_forward_unit: directed vector table, hand-written stall/timeout/reset
// sequences, and random stimulus against a pipeline-history reference model.
module tb_hazard_forward_unit;

  localparam int unsigned TIMEOUT = 15;

  logic clk = 1'b0;
  logic reset_n;
  int   checks   = 0;
  int   failures = 0;

  hazard_forward_unit_if bus ();

  hazard_forward_unit #(.MEM_TIMEOUT(TIMEOUT)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       ur;
    logic [4:0] iwr;
    logic       irw;
    logic       imr;
    logic       rdy;
    logic [1:0] fa;
    logic [1:0] fb;
    logic       pcw;
    logic       bub;
    logic       frz;
    logic       err;
  } vec_t;

  function automatic vec_t mk(int rs, int rt, int ur, int iwr, int irw, int imr, int rdy,
                              int fa, int fb, int pcw, int bub, int frz, int err);
    vec_t v;
    v.rs = 5'(rs);  v.rt = 5'(rt);  v.ur = 1'(ur);
    v.iwr = 5'(iwr); v.irw = 1'(irw); v.imr = 1'(imr); v.rdy = 1'(rdy);
    v.fa = 2'(fa);  v.fb = 2'(fb);
    v.pcw = 1'(pcw); v.bub = 1'(bub); v.frz = 1'(frz); v.err = 1'(err);
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.id_rs         = v.rs;
    bus.id_rt         = v.rt;
    bus.id_uses_rt    = v.ur;
    bus.idex_writeReg = v.iwr;
    bus.idex_regwrite = v.irw;
    bus.idex_memread  = v.imr;
    bus.mem_ready     = v.rdy;
  endtask

  task automatic check_outs(input string tag, input vec_t v);
    check({tag, ".fwdA"},        int'(bus.fwdA),        int'(v.fa));
    check({tag, ".fwdB"},        int'(bus.fwdB),        int'(v.fb));
    check({tag, ".pc_write"},    int'(bus.pc_write),    int'(v.pcw));
    check({tag, ".ifid_write"},  int'(bus.ifid_write),  int'(v.pcw));
    check({tag, ".idex_bubble"}, int'(bus.idex_bubble), int'(v.bub));
    check({tag, ".pipe_freeze"}, int'(bus.pipe_freeze), int'(v.frz));
    check({tag, ".mem_err"},     int'(bus.mem_err),     int'(v.err));
  endtask

  task automatic check_reset(input string tag);
    check_outs(tag, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    check({tag, ".exmem_wr"}, int'(bus.exmem_wr), 0);
    check({tag, ".exmem_mr"}, int'(bus.exmem_mr), 0);
    check({tag, ".memwb_wr"}, int'(bus.memwb_wr), 0);
  endtask

  task automatic apply(input vec_t v, input string tag);
    drive(v);
    @(negedge clk);
    check_outs(tag, v);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // Reference model: what sits in the two stages after ID/EX, and how long memory has stalled.
  int  stage_wr[2];
  bit  stage_rw[2];
  bit  stage_mr;
  int  m_fa, m_fb;
  bit  m_err, m_waiting;
  int  m_waited;

  task automatic model_reset();
    stage_wr = '{0, 0};
    stage_rw = '{0, 0};
    stage_mr = 0;
    m_fa = 0; m_fb = 0;
    m_err = 0; m_waiting = 0; m_waited = 0;
  endtask

  // Code = 1 + age of the youngest producer of src among {ID/EX, EX/MEM}; 0 if none.
  function automatic int pick(int src, int iwr, bit irw);
    int wr[2];
    bit rw[2];
    wr[0] = iwr; rw[0] = irw;
    wr[1] = stage_wr[0]; rw[1] = stage_rw[0];
    for (int k = 0; k < 2; k++) begin
      if (rw[k] && wr[k] != 0 && wr[k] == src) return k + 1;
    end
    return 0;
  endfunction

  vec_t vecs[22];

  initial begin
    vec_t v;
    bit lu, frz, bub;
    int na, nb;

    vecs[0]  = mk(1, 2, 1, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0);
    vecs[1]  = mk(3, 5, 1, 3, 1, 0, 1, 0, 0, 1, 0, 0, 0);
    vecs[2]  = mk(0, 0, 0, 4, 1, 0, 1, 1, 0, 1, 0, 0, 0);
    vecs[3]  = mk(1, 2, 1, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0);
    vecs[4]  = mk(1, 2, 1, 3, 1, 0, 1, 0, 0, 1, 0, 0, 0);
    vecs[5]  = mk(3, 3, 1, 3, 1, 0, 1, 0, 0, 1, 0, 0, 0);
    vecs[6]  = mk(0, 0, 0, 6, 1, 0, 1, 1, 1, 1, 0, 0, 0);
    vecs[7]  = mk(0, 0, 1, 0, 1, 0, 1, 0, 0, 1, 0, 0, 0);
    vecs[8]  = mk(0, 0, 1, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0);
    vecs[9]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0);
    vecs[10] = mk(1, 5, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0);
    vecs[11] = mk(2, 5, 1, 5, 1, 1, 1, 0, 0, 0, 1, 0, 0);
    vecs[12] = mk(2, 5, 1, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0);
    vecs[13] = mk(0, 0, 0, 6, 1, 0, 1, 0, 2, 1, 0, 0, 0);
    vecs[14] = mk(2, 5, 0, 5, 1, 1, 1, 0, 0, 1, 0, 0, 0);
    vecs[15] = mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0);
    vecs[16] = mk(0, 0, 0, 7, 1, 1, 1, 0, 0, 1, 0, 0, 0);
    vecs[17] = mk(9, 0, 0, 9, 1, 1, 0, 0, 0, 0, 0, 1, 0);
    vecs[18] = mk(9, 0, 0, 9, 1, 1, 0, 0, 0, 0, 0, 1, 0);
    vecs[19] = mk(9, 0, 0, 9, 1, 1, 1, 0, 0, 0, 1, 0, 0);
    vecs[20] = mk(9, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0);
    vecs[21] = mk(0, 0, 0, 0, 0, 0, 1, 2, 0, 1, 0, 0, 0);

    // Reset values, with load-use inputs present to show reset masks the stall
    reset_n = 1'b0;
    drive(mk(5, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    check_reset("reset");
    do_reset();

    foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

    // Memory wait: three frozen cycles hold fwdA=10, flow resumes on the fourth
    do_reset();
    apply(mk(0, 0, 0, 3, 1, 0, 1, 0, 0, 1, 0, 0, 0), "mw_pre0");
    apply(mk(3, 0, 0, 4, 1, 1, 1, 0, 0, 1, 0, 0, 0), "mw_pre1");
    for (int i = 0; i < 3; i++)
      apply(mk(0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 1, 0), $sformatf("mw_wait%0d", i));
    apply(mk(0, 0, 0, 0, 0, 0, 1, 2, 0, 1, 0, 0, 0), "mw_release");
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), "mw_after");

    // Reset asserted mid-stall clears the pending load immediately
    do_reset();
    apply(mk(0, 0, 0, 4, 1, 1, 1, 0, 0, 1, 0, 0, 0), "rs_pre");
    apply(mk(4, 0, 0, 4, 1, 1, 0, 0, 0, 0, 0, 1, 0), "rs_frozen");
    drive(mk(4, 0, 0, 4, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_reset("rs_async");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), "rs_after");

    // Timeout: mem_ready low for 20 cycles, ERROR after TIMEOUT wait cycles
    apply(mk(0, 0, 0, 4, 1, 1, 1, 0, 0, 1, 0, 0, 0), "to_pre");
    for (int i = 0; i < 20; i++)
      apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, (i >= int'(TIMEOUT) + 1) ? 1 : 0),
            $sformatf("to_wait%0d", i));
    for (int i = 0; i < 2; i++)
      apply(mk(5, 0, 0, 5, 1, 1, 1, 0, 0, 0, 0, 1, 1), $sformatf("to_sticky%0d", i));
    drive(mk(5, 0, 0, 5, 1, 1, 1, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_reset("to_reset");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), "to_after");

    // Random stimulus against the reference model
    do_reset();
    model_reset();
    for (int n = 0; n < 600; n++) begin
      v = mk($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
             $urandom_range(0, 3), $urandom_range(0, 1), ($urandom_range(0, 99) < 40) ? 1 : 0,
             ($urandom_range(0, 99) < 75) ? 1 : 0, 0, 0, 0, 0, 0, 0);
      drive(v);
      @(negedge clk);
      lu  = v.imr && v.iwr != 0 && (v.iwr == v.rs || (v.ur && v.iwr == v.rt));
      frz = m_err || (stage_mr && !v.rdy);
      bub = !frz && lu;
      v.fa = 2'(m_fa); v.fb = 2'(m_fb);
      v.pcw = !(frz || bub); v.bub = bub; v.frz = frz; v.err = m_err;
      check_outs($sformatf("rnd%0d", n), v);
      check($sformatf("rnd%0d.exmem_wr", n), int'(bus.exmem_wr), stage_wr[0]);
      check($sformatf("rnd%0d.memwb_wr", n), int'(bus.memwb_wr), stage_wr[1]);
      if (!m_err) begin
        if (frz) begin
          if (m_waiting) begin
            m_waited++;
            if (m_waited == int'(TIMEOUT)) m_err = 1;
          end else begin
            m_waiting = 1;
            m_waited  = 0;
          end
        end else begin
          m_waiting = 0;
        end
      end
      if (!frz) begin
        na = bub ? 0 : pick(v.rs, v.iwr, v.irw);
        nb = bub ? 0 : pick(v.rt, v.iwr, v.irw);
        m_fa = na; m_fb = nb;
        stage_wr[1] = stage_wr[0]; stage_rw[1] = stage_rw[0];
        stage_wr[0] = v.iwr; stage_rw[0] = v.irw; stage_mr = v.imr;
      end
      @(posedge clk);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_forward_unit.md
HAZARD_FORWARD_UNIT -- requirements
Module: hazard_forward_unit

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15, giving the freeze cycles tolerated before mem_err (range 1..15).
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port id_rs  in  5  rs field of the instruction in IF/ID.
REQ-005 SHALL have port id_rt  in  5  rt field of the instruction in IF/ID.
REQ-006 SHALL have port id_uses_rt  in  1  1 = the IF/ID instruction reads rt as a source.
REQ-007 SHALL have port idex_writeReg  in  5  destination register of the ID/EX instruction, after the regdest mux.
REQ-008 SHALL have port idex_regwrite  in  1  the ID/EX instruction writes the register file.
REQ-009 SHALL have port idex_memread  in  1  the ID/EX instruction is a load.
REQ-010 SHALL have port mem_ready  in  1  data memory completes the current EX/MEM access this cycle.
REQ-011 SHALL have port fwdA, fwdB  out  2 each  execute-stage forward selects: 00 ID/EX, 01 EX/MEM, 10 MEM/WB; 11 is never driven.
REQ-012 SHALL have port pc_write, ifid_write  out  1 each  enable PC and IF/ID updates.
REQ-013 SHALL have port idex_bubble  out  1  load ID/EX with a NOP this cycle.
REQ-014 SHALL have port pipe_freeze  out  1  hold every pipeline register this cycle.
REQ-015 SHALL have port mem_err  out  1  sticky memory-timeout flag.

Function
REQ-016 SHALL hold shadow registers exmem_wr[4:0], exmem_rw, exmem_mr and memwb_wr[4:0], memwb_rw; on each non-frozen edge exmem_* <= idex_* and memwb_* <= exmem_*.
REQ-017 SHALL register fwdA/fwdB one stage ahead: on each non-frozen, non-bubble edge, compute the select from id_rs (A) or id_rt (B) and load it into fwdA_q/fwdB_q.
REQ-018 SHALL compute the select as: 01 if idex_regwrite && idex_writeReg!=0 && match; else 10 if exmem_rw && exmem_wr!=0 && match; else 00. The EX/MEM hazard takes priority.
REQ-019 SHALL load fwdA_q/fwdB_q with 00 on a bubble edge, because a NOP enters ID/EX.
REQ-020 SHALL set load_use = idex_memread && idex_writeReg!=0 && (idex_writeReg==id_rs || (id_uses_rt && idex_writeReg==id_rt)), combinationally.
REQ-021 SHALL, on load_use in state RUN without freeze, assert idex_bubble=1 and pc_write=ifid_write=0 for exactly that cycle. The shadows still advance, so the load is forwarded via 10 on the retry.
REQ-022 SHALL set pipe_freeze = (exmem_mr && !mem_ready) || state==ERROR, combinationally. Freeze forces pc_write=ifid_write=0 and idex_bubble=0, and holds all shadow and fwd registers.
REQ-023 SHALL give freeze priority over load_use when both occur in the same cycle. load_use is re-evaluated after the freeze ends.
REQ-024 SHALL implement FSM states RUN, MEMWAIT and ERROR with these transitions: RUN->MEMWAIT on freeze; MEMWAIT->RUN when mem_ready=1; MEMWAIT->ERROR when the wait counter reaches MEM_TIMEOUT with mem_ready still 0; ERROR is terminal until reset.
REQ-025 SHALL use a 4-bit wait counter that clears on entering MEMWAIT, increments each MEMWAIT cycle, and saturates without wrap-around.
REQ-026 SHALL assert mem_err=1 in ERROR only.
REQ-027 SHALL drive pc_write=ifid_write=1, idex_bubble=0 and pipe_freeze=0 in RUN when no hazard is present.

Reset
REQ-028 SHALL, while reset_n=0, asynchronously force state=RUN, counter=0, all shadows=0, fwdA=fwdB=00, mem_err=0.
REQ-029 SHALL, during reset, drive pc_write=ifid_write=1 and idex_bubble=pipe_freeze=0.
REQ-030 SHALL, on reset asserted mid-stall or in ERROR, discard all pending state with no residual bubble after release.

Structure
REQ-031 SHALL place the FWD_IDEX/FWD_EXMEM/FWD_MEMWB encodings and the FSM state enum in a shared package, which the execute-stage forward muxes also use.
REQ-032 SHALL contain one sub-module, fwd_select, the combinational 5-bit compare and priority encode per operand, instantiated twice (A, B).

Verification
REQ-033 SHALL cover EX/MEM forward: add $3 followed by sub using $3 as rs -> fwdA=01 in sub's EX cycle, fwdB=00.
REQ-034 SHALL cover double hazard: add $3, add $3, then use $3 -> fwd=01, not 10; an instruction writing $0 followed by a use of $0 -> fwd=00.
REQ-035 SHALL cover load-use: lw $5 followed by add using $5 as rt with id_uses_rt=1 -> one cycle of idex_bubble=1, pc_write=0, then fwdB=10 in add's EX cycle; with id_uses_rt=0 -> no stall.
REQ-036 SHALL cover memory wait: load in EX/MEM with mem_ready low for 3 cycles -> pipe_freeze=1 for 3 cycles, fwd values held, RUN resumes on the 4th cycle.
REQ-037 SHALL cover timeout: mem_ready held low for 20 cycles with MEM_TIMEOUT=15 -> ERROR entered, mem_err=1 and freeze sticky; reset_n pulse -> all outputs return to reset values.
REQ-038 SHALL cover simultaneous load-use and freeze -> no bubble during freeze, bubble in the first unfrozen cycle.
